ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_if.sv | 30 +++
 rtl/ifu.sv | 105 ++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared widths, reset PC and FSM encoding for the instruction fetch unit.
package ifu_pkg;
   localparam int ysyx_23060251_reg_bus  = 64;
   localparam int ysyx_23060251_inst_bus = 32;

   localparam logic [ysyx_23060251_reg_bus-1:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } ifu_state_e;

   function automatic logic pc_aligned(input logic [1:0] pc_lsb);
      return pc_lsb == 2'b00;
   endfunction
endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: redirect from execute, memory request/response, decode handoff.
interface ifu_if;
   import ifu_pkg::*;

   logic                              redirect_valid_i;
   logic [ysyx_23060251_reg_bus-1:0]  redirect_pc_i;
   logic                              req_valid_o;
   logic                              req_ready_i;
   logic [ysyx_23060251_reg_bus-1:0]  req_addr_o;
   logic                              rsp_valid_i;
   logic [ysyx_23060251_inst_bus-1:0] rsp_data_i;
   logic                              rsp_err_i;
   logic                              inst_valid_o;
   logic                              inst_ready_i;
   logic [ysyx_23060251_inst_bus-1:0] inst_o;
   logic [ysyx_23060251_reg_bus-1:0]  pc_o;
   logic                              fault_o;

   modport master (
      input  redirect_valid_i, redirect_pc_i, req_ready_i, rsp_valid_i, rsp_data_i,
             rsp_err_i, inst_ready_i,
      output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o
   );

   modport slave (
      output redirect_valid_i, redirect_pc_i, req_ready_i, rsp_valid_i, rsp_data_i,
             rsp_err_i, inst_ready_i,
      input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, fault_o
   );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding decode.
// state | meaning
// REQ   | present pc to memory; a misaligned pc skips memory and becomes a fault
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction held for decode until accepted
// DROP  | waiting out the response of a request made obsolete by a redirect
module ifu
   import ifu_pkg::*;
#(
   parameter logic [ysyx_23060251_reg_bus-1:0] RESET_PC = IFU_RESET_PC
) (
   input  logic  clock,
   input  logic  reset,
   ifu_if.master bus
);
   ifu_state_e                        state_q, state_d;
   logic [ysyx_23060251_reg_bus-1:0]  pc_q, pc_d;
   logic [ysyx_23060251_reg_bus-1:0]  pc_out_q, pc_out_d;
   logic [ysyx_23060251_inst_bus-1:0] inst_q, inst_d;
   logic                              fault_q, fault_d;
   logic                              req_valid_q, req_valid_d;
   logic                              inst_valid_q, inst_valid_d;
   logic                              req_fire;

   // A handshake only counts when a request was actually presented.
   assign req_fire = req_valid_q & bus.req_ready_i;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      inst_d   = inst_q;
      fault_d  = fault_q;
      unique case (state_q)
         ST_REQ: begin
            if (bus.redirect_valid_i) begin
               pc_d = bus.redirect_pc_i;
               if (req_fire) state_d = ST_DROP;
            end else if (!pc_aligned(pc_q[1:0])) begin
               state_d  = ST_HOLD;
               inst_d   = '0;
               fault_d  = 1'b1;
               pc_out_d = pc_q;
            end else if (req_fire) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.redirect_valid_i) begin
               pc_d    = bus.redirect_pc_i;
               state_d = bus.rsp_valid_i ? ST_REQ : ST_DROP;
            end else if (bus.rsp_valid_i) begin
               state_d  = ST_HOLD;
               inst_d   = bus.rsp_data_i;
               fault_d  = bus.rsp_err_i;
               pc_out_d = pc_q;
            end
         end
         ST_HOLD: begin
            if (bus.redirect_valid_i) begin
               pc_d    = bus.redirect_pc_i;
               state_d = ST_REQ;
            end else if (bus.inst_ready_i) begin
               pc_d    = pc_q + 64'd4;
               state_d = ST_REQ;
            end
         end
         ST_DROP: begin
            // A redirect here only retargets; the stale response must still drain.
            if (bus.redirect_valid_i) pc_d = bus.redirect_pc_i;
            if (bus.rsp_valid_i) state_d = ST_REQ;
         end
         default: state_d = ST_REQ;
      endcase
      req_valid_d  = (state_d == ST_REQ) && pc_aligned(pc_d[1:0]);
      inst_valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         pc_out_q     <= '0;
         inst_q       <= '0;
         fault_q      <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_out_q     <= pc_out_d;
         inst_q       <= inst_d;
         fault_q      <= fault_d;
         req_valid_q  <= req_valid_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign bus.req_valid_o  = req_valid_q;
   assign bus.req_addr_o   = pc_q;
   assign bus.inst_valid_o = inst_valid_q;
   assign bus.inst_o       = inst_q;
   assign bus.pc_o         = pc_out_q;
   assign bus.fault_o      = fault_q;
endmodule
